// File: rtl/bldc_startup_sequencer_if.sv
// bldc_startup_sequencer_if: control/status bundle between the startup sequencer and its surroundings
interface bldc_startup_sequencer_if #(
  parameter int GAIN_W = 16
);
  logic              start;
  logic              stop;
  logic              clear_fault;
  logic              encoder_change;
  logic [15:0]       desired_velocity;
  logic              apply_initial_commutation;
  logic [GAIN_W-1:0] align_gain;
  logic              reset_encoder_count;
  logic              commutation_enable;
  logic              loop_enable;
  logic              fault;
  logic [2:0]        state_code;
  modport master (
    output start, stop, clear_fault, encoder_change, desired_velocity,
    input  apply_initial_commutation, align_gain, reset_encoder_count,
           commutation_enable, loop_enable, fault, state_code
  );
  modport slave (
    input  start, stop, clear_fault, encoder_change, desired_velocity,
    output apply_initial_commutation, align_gain, reset_encoder_count,
           commutation_enable, loop_enable, fault, state_code
  );
endinterface

// File: rtl/bldc_startup_sequencer.sv
// bldc_startup_sequencer: align-ramp / hold / zero / run sequencer with optional stall fault (BLDC_STALL_DETECT_EN)
module bldc_startup_sequencer #(
  parameter int GAIN_W           = 16,
  parameter int RAMP_STEP_CYCLES = 1024,
  parameter int ALIGN_GAIN_MAX   = 256,
  parameter int HOLD_CYCLES      = 65536,
  parameter int STALL_CYCLES     = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  bldc_startup_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, RAMP = 3'd1, HOLD = 3'd2, ZERO = 3'd3, RUN = 3'd4, FAULT = 3'd5} state_t;
  localparam int TMAX = RAMP_STEP_CYCLES > HOLD_CYCLES ? RAMP_STEP_CYCLES : HOLD_CYCLES;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] RAMP_LAST = TW'(RAMP_STEP_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [GAIN_W-1:0] GMAX = GAIN_W'(ALIGN_GAIN_MAX);
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic apply_initial_commutation_q, apply_initial_commutation_d;
  logic [GAIN_W-1:0] align_gain_q, align_gain_d;
  logic reset_encoder_count_q, reset_encoder_count_d;
  logic commutation_enable_q, commutation_enable_d;
  logic loop_enable_q, loop_enable_d;
  logic fault_q, fault_d;
`ifdef BLDC_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES) + 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
  logic [SW-1:0] stall_q, stall_d;
`else
  logic unused_in;
  assign unused_in = ^{bus.encoder_change, bus.desired_velocity};
`endif
  // next state, phase timers and registered output values derived from the next state
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    gain_d = gain_q;
`ifdef BLDC_STALL_DETECT_EN
    stall_d = '0;
`endif
    if (bus.stop && state_q inside {RAMP, HOLD, ZERO, RUN}) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start && !bus.stop) state_d = RAMP;
        RAMP: begin
          if (GMAX == '0) begin
            state_d = HOLD;
          end else if (tmr_q == RAMP_LAST) begin
            tmr_d = '0;
            gain_d = gain_q + 1'b1;
            if (gain_d == GMAX) state_d = HOLD;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        HOLD: begin
          if (tmr_q == HOLD_LAST) begin
            tmr_d = '0;
            state_d = ZERO;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ZERO: state_d = RUN;
        RUN: begin
`ifdef BLDC_STALL_DETECT_EN
          if (!bus.encoder_change && bus.desired_velocity != '0) begin
            if (stall_q == STALL_LAST) state_d = FAULT;
            else stall_d = stall_q + 1'b1;
          end
`endif
        end
        FAULT: if (bus.clear_fault) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (!(state_d inside {RAMP, HOLD, ZERO})) begin
      tmr_d = '0;
      gain_d = '0;
    end
    apply_initial_commutation_d = state_d inside {RAMP, HOLD, ZERO};
    align_gain_d = gain_d;
    reset_encoder_count_d = state_d == ZERO;
    commutation_enable_d = state_d inside {RAMP, HOLD, ZERO, RUN};
    loop_enable_d = state_d == RUN;
    fault_d = state_d == FAULT;
  end
  // state, counters and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr_q <= '0;
      gain_q <= '0;
      apply_initial_commutation_q <= 1'b0;
      align_gain_q <= '0;
      reset_encoder_count_q <= 1'b0;
      commutation_enable_q <= 1'b0;
      loop_enable_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      gain_q <= gain_d;
      apply_initial_commutation_q <= apply_initial_commutation_d;
      align_gain_q <= align_gain_d;
      reset_encoder_count_q <= reset_encoder_count_d;
      commutation_enable_q <= commutation_enable_d;
      loop_enable_q <= loop_enable_d;
      fault_q <= fault_d;
    end
  end
`ifdef BLDC_STALL_DETECT_EN
  // cycles in RUN without encoder motion while a nonzero velocity is commanded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
  assign bus.apply_initial_commutation = apply_initial_commutation_q;
  assign bus.align_gain = align_gain_q;
  assign bus.reset_encoder_count = reset_encoder_count_q;
  assign bus.commutation_enable = commutation_enable_q;
  assign bus.loop_enable = loop_enable_q;
  assign bus.fault = fault_q;
  assign bus.state_code = state_q;
endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// tb_bldc_startup_sequencer: scoreboard bench for bldc_startup_sequencer, model honours BLDC_STALL_DETECT_EN
module tb_bldc_startup_sequencer;
  localparam int GW = 8, STEP = 4, GMAX = 8, HOLD = 10, STALL = 20;
  localparam int RAMP_LEN = (GMAX == 0) ? 1 : GMAX * STEP;
`ifdef BLDC_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  typedef struct packed {
    logic          aic;
    logic [GW-1:0] gain;
    logic          rec;
    logic          ce;
    logic          le;
    logic          flt;
    logic [2:0]    code;
  } out_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bldc_startup_sequencer_if #(.GAIN_W(GW)) bus ();
  bldc_startup_sequencer #(
    .GAIN_W(GW), .RAMP_STEP_CYCLES(STEP), .ALIGN_GAIN_MAX(GMAX),
    .HOLD_CYCLES(HOLD), .STALL_CYCLES(STALL)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  out_t q[$];
  int checks = 0, errors = 0;
  int ph = 0, t = 0, stall = 0;
  function automatic out_t expected();
    out_t e;
    e.aic = ph inside {1, 2, 3};
    e.gain = ph == 1 ? GW'(t / STEP) : ph inside {2, 3} ? GW'(GMAX) : '0;
    e.rec = ph == 3;
    e.ce = ph inside {1, 2, 3, 4};
    e.le = ph == 4;
    e.flt = ph == 5;
    e.code = 3'(ph);
    return e;
  endfunction
  function automatic out_t actual();
    out_t a;
    a.aic = bus.apply_initial_commutation;
    a.gain = bus.align_gain;
    a.rec = bus.reset_encoder_count;
    a.ce = bus.commutation_enable;
    a.le = bus.loop_enable;
    a.flt = bus.fault;
    a.code = bus.state_code;
    return a;
  endfunction
  task automatic model(input bit rst, input bit st, input bit sp, input bit cf, input bit enc, input int vel);
    if (!rst) begin
      ph = 0; t = 0; stall = 0;
    end else if (sp && ph inside {1, 2, 3, 4}) begin
      ph = 0; t = 0; stall = 0;
    end else begin
      case (ph)
        0: if (st && !sp) begin ph = 1; t = 0; end
        1: if (t + 1 >= RAMP_LEN) begin ph = 2; t = 0; end else t++;
        2: if (t + 1 >= HOLD) begin ph = 3; t = 0; end else t++;
        3: begin ph = 4; stall = 0; end
        4: if (STALL_EN) begin
          stall = (enc || vel == 0) ? 0 : stall + 1;
          if (stall >= STALL) begin ph = 5; stall = 0; end
        end
        5: if (cf) ph = 0;
        default: ph = 0;
      endcase
    end
  endtask
  task automatic step(input bit st, input bit sp, input bit cf, input bit enc, input int vel);
    bus.start = st;
    bus.stop = sp;
    bus.clear_fault = cf;
    bus.encoder_change = enc;
    bus.desired_velocity = 16'(vel);
    model(reset, st, sp, cf, enc, vel);
    q.push_back(expected());
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h (aic,gain,rec,ce,le,fault,code)", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) check("outputs", actual(), q.pop_front());
  end
  initial begin
    out_t z, pre;
    z = '0;
    bus.start = 0; bus.stop = 0; bus.clear_fault = 0; bus.encoder_change = 0; bus.desired_velocity = 0;
    #1 reset = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (50) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (36) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (43) step(0, 0, 0, 0, 100);
    repeat (1000) step(0, 0, 0, 0, 100);
    step(0, 0, 1, 0, 100);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (43) step(0, 0, 0, 0, 0);
    for (int i = 1; i <= 120; i++) step(0, 0, 0, i % 19 == 0, 100);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (43) step(0, 0, 0, 0, 0);
    repeat (19) step(0, 0, 0, 0, 100);
    step(0, 0, 0, 1, 100);
    repeat (10) step(0, 0, 0, 0, 100);
    repeat (50) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    pre = expected();
    check("pre_reset", actual(), pre);
    reset = 1'b0;
    #1;
    check("async_reset", actual(), z);
    repeat (2) step(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3000) step($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 65535)));
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bldc_startup_sequencer.md
Name: bldc_startup_sequencer

Overview:
Control unit that sequences the BLDC velocity loop from power-up to closed-loop run. It drives open-loop rotor alignment with a ramped gain, holds the rotor, then zeroes the encoder count. It then hands commutation and the PI loop over to the velocity datapath. In run it supervises the encoder for stalls and latches a fault. Sits beside the encoder, tick-timer and commutation blocks; its outputs gate commutation enable, the encoder-count reset and the initial-commutation override.

Parameters:
GAIN_W, 16, width of align_gain (matches commutation gain input)
RAMP_STEP_CYCLES, 1024, clk cycles per +1 step of align_gain during ramp (>=1)
ALIGN_GAIN_MAX, 256, final alignment gain (< 2^GAIN_W)
HOLD_CYCLES, 65536, clk cycles rotor is held at ALIGN_GAIN_MAX (>=1)
STALL_CYCLES, 1000000, cycles in RUN with nonzero command and no encoder change before fault (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; begin startup when in IDLE
stop  in  1  level; abort to IDLE from any non-FAULT state
clear_fault  in  1  level; leave FAULT
encoder_change  in  1  1-cycle pulse per quadrature state change
desired_velocity  in  16  commanded velocity; used only for stall qualification
apply_initial_commutation  out  1  forces fixed alignment commutation vector
align_gain  out  GAIN_W  gain used while apply_initial_commutation=1
reset_encoder_count  out  1  1-cycle pulse zeroing the encoder count
commutation_enable  out  1  enables commutation PWM
loop_enable  out  1  enables PI controller / IIR filter update
fault  out  1  latched stall fault
state_code  out  3  IDLE=0 RAMP=1 HOLD=2 ZERO=3 RUN=4 FAULT=5

Behaviour:
- All outputs registered. During reset assertion: state IDLE, all outputs 0, all counters 0.
- IDLE: outputs 0. start=1 and stop=0 -> RAMP on next edge. Counters cleared.
- RAMP: apply_initial_commutation=1, commutation_enable=1, loop_enable=0.
  - align_gain starts 0 and increments by 1 every RAMP_STEP_CYCLES cycles.
  - On the edge where align_gain becomes ALIGN_GAIN_MAX, state -> HOLD; RAMP lasts exactly ALIGN_GAIN_MAX*RAMP_STEP_CYCLES cycles.
  - ALIGN_GAIN_MAX=0: RAMP lasts 1 cycle.
- HOLD: align_gain=ALIGN_GAIN_MAX, override still on. Lasts exactly HOLD_CYCLES cycles, then -> ZERO.
- ZERO: exactly 1 cycle; reset_encoder_count=1, override and gain held. -> RUN.
- RUN: apply_initial_commutation=0, align_gain=0, commutation_enable=1, loop_enable=1. Stays until stop or stall.
- Stall counter (RUN only):
  - Clears on encoder_change=1 or desired_velocity==0; otherwise +1 per cycle.
  - Reaching STALL_CYCLES -> FAULT.
  - encoder_change on the threshold cycle wins: clears the counter, no fault.
- FAULT: fault=1; all other outputs 0. clear_fault=1 -> IDLE. start and stop are ignored.
- Priority in non-IDLE, non-FAULT states: stop > stall/timer transitions. stop and start asserted together in IDLE: stay IDLE.
- stop mid-RAMP/HOLD/ZERO: next edge IDLE, gain 0, no reset_encoder_count pulse.
- Counter widths: $clog2 of the respective parameter +1; no wrap permitted.
- Reset mid-operation returns immediately (asynchronously) to IDLE values.

Optional Feature:
BLDC_STALL_DETECT_EN
- Defined: stall counter and FAULT entry from RUN are implemented as above.
- Undefined: stall counter removed; RUN never enters FAULT, so fault stays 0. clear_fault is unused; state code 5 is unreachable.

Test Plan:
Parameters for all scenarios: GAIN_W=8, RAMP_STEP_CYCLES=4, ALIGN_GAIN_MAX=8, HOLD_CYCLES=10, STALL_CYCLES=20.
- Nominal start: reset released, start pulsed 1 cycle -> state_code 1; align_gain 0,0,0,0,1,... stepping every 4 cycles; reaches 8 and HOLD 32 cycles after RAMP entry; ZERO at +42 with single reset_encoder_count pulse; RUN at +43 with loop_enable=1 and align_gain=0.
- Stop mid-HOLD: stop at HOLD cycle 5 -> next edge IDLE, all outputs 0, no reset_encoder_count pulse ever seen.
- Stall: in RUN, desired_velocity=100, no encoder_change -> fault=1 and state_code=5 after exactly 20 cycles. clear_fault -> IDLE. Repeat with an encoder_change pulse every 19 cycles -> never faults.
- Stall boundary: encoder_change on the 20th cycle -> no fault. desired_velocity=0 for 50 cycles -> no fault.
- Async reset: assert reset low mid-RAMP (between edges) -> outputs 0 and state_code 0 immediately, without waiting for a clock edge.
- Macro off: same stimulus as the stall scenario -> stays in RUN for 1000 cycles, fault=0.
